pe_inject_fifo: RTL and testbench

//  Injection stage between a processing element (PE) and the PE input port of an nbyn mesh switch.

---
 rtl/pe_inject_fifo_pkg.sv | 10 +
 rtl/noc_sync_fifo.sv | 43 ++++
 rtl/pe_inject_fifo.sv | 45 ++++
 tb/tb_pe_inject_fifo.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pe_inject_fifo_pkg.sv
// pe_inject_fifo_pkg: packet field offsets shared by the injection stage and the mesh switch
package pe_inject_fifo_pkg;
  localparam int X_LSB = 0;
  function automatic int y_lsb(int xs);
    return xs;
  endfunction
  function automatic int payload_lsb(int xs, int ys);
    return xs + ys;
  endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock first-word-fall-through FIFO with synchronous flush
module noc_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign wr_en = push & ~full & ~flush;
  assign rd_en = pop & ~empty & ~flush;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/pe_inject_fifo.sv
// pe_inject_fifo: packs PE destination and payload into a packet and buffers it toward the mesh switch
module pe_inject_fifo
  import pe_inject_fifo_pkg::*;
#(
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0,
  parameter int data_width = 256,
  parameter int x_size = 1,
  parameter int y_size = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [x_size-1:0]        i_dst_x,
  input  logic [y_size-1:0]        i_dst_y,
  input  logic [data_width-1:0]    i_payload,
  input  logic                     i_flush,
  output logic                     o_valid_sw,
  output logic [total_width-1:0]   o_data_sw,
  input  logic                     i_ready_sw,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [CNT_W-1:0]         o_inj_count
);
  logic [total_width-1:0] pkt;
  logic full, empty;
  always_comb begin
    pkt = '0;
    pkt[X_LSB +: x_size] = i_dst_x;
    pkt[y_lsb(x_size) +: y_size] = i_dst_y;
    pkt[payload_lsb(x_size, y_size) +: data_width] = i_payload;
  end
  noc_sync_fifo #(.W(total_width), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push(i_valid), .pop(i_ready_sw), .flush(i_flush),
    .din(pkt), .dout(o_data_sw), .full(full), .empty(empty), .count(o_count)
  );
  assign o_ready = ~full;
  assign o_valid_sw = ~empty;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) o_inj_count <= '0;
    else if (o_valid_sw & i_ready_sw & ~i_flush) o_inj_count <= o_inj_count + 1'b1;
endmodule

// File: tb/tb_pe_inject_fifo.sv
// tb_pe_inject_fifo: directed checks of packet forming, FWFT buffering, back-pressure, flush and counter wrap
module tb_pe_inject_fifo;
  logic clk = 0, rstn = 0;
  logic i_valid = 0, i_flush = 0, i_ready_sw = 0;
  logic i_dst_x = 0, i_dst_y = 0;
  logic [7:0] i_payload = 0;
  logic o_ready, o_valid_sw, w_ready, w_valid;
  logic [9:0] o_data_sw, w_data;
  logic [2:0] o_count, w_count;
  logic [15:0] o_inj_count;
  logic [3:0] w_inj;
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  pe_inject_fifo #(.data_width(8), .x_size(1), .y_size(1), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready), .i_dst_x(i_dst_x),
    .i_dst_y(i_dst_y), .i_payload(i_payload), .i_flush(i_flush), .o_valid_sw(o_valid_sw),
    .o_data_sw(o_data_sw), .i_ready_sw(i_ready_sw), .o_count(o_count), .o_inj_count(o_inj_count)
  );
  pe_inject_fifo #(.data_width(8), .x_size(1), .y_size(1), .DEPTH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(w_ready), .i_dst_x(i_dst_x),
    .i_dst_y(i_dst_y), .i_payload(i_payload), .i_flush(i_flush), .o_valid_sw(w_valid),
    .o_data_sw(w_data), .i_ready_sw(i_ready_sw), .o_count(w_count), .o_inj_count(w_inj)
  );
  function automatic logic [9:0] pkt(input logic x, input logic y, input logic [7:0] p);
    return {p, y, x};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic x, input logic y, input logic [7:0] p);
    i_valid = v; i_dst_x = x; i_dst_y = y; i_payload = p;
  endtask
  task automatic test_reset;
    #12 rstn = 1;
    tick;
    drive(1, 1, 1, 8'h33);
    i_ready_sw = 0;
    tick;
    drive(0, 0, 0, 0);
    tick;
    vec++; if (o_count !== 3'd1) begin errs++; $display("FAIL reset_pre_count got %0d exp 1", o_count); end
    #3 rstn = 0;
    #1;
    vec++; if (o_valid_sw !== 1'b0) begin errs++; $display("FAIL reset_valid got %0b exp 0", o_valid_sw); end
    vec++; if (o_count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", o_count); end
    vec++; if (o_inj_count !== 16'd0) begin errs++; $display("FAIL reset_inj got %0d exp 0", o_inj_count); end
    #1 rstn = 1;
    #1;
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %0b exp 1", o_ready); end
  endtask
  task automatic test_single;
    tick;
    drive(1, 1, 0, 8'hA5);
    i_ready_sw = 1;
    vec++; if (o_valid_sw !== 1'b0) begin errs++; $display("FAIL single_pre_valid got %0b exp 0", o_valid_sw); end
    tick;
    drive(0, 0, 0, 0);
    vec++; if (o_valid_sw !== 1'b1) begin errs++; $display("FAIL single_valid got %0b exp 1", o_valid_sw); end
    vec++; if (o_data_sw !== 10'h295) begin errs++; $display("FAIL single_data got %h exp 295", o_data_sw); end
    vec++; if (o_inj_count !== 16'd0) begin errs++; $display("FAIL single_inj0 got %0d exp 0", o_inj_count); end
    tick;
    vec++; if (o_inj_count !== 16'd1) begin errs++; $display("FAIL single_inj1 got %0d exp 1", o_inj_count); end
    vec++; if (o_valid_sw !== 1'b0) begin errs++; $display("FAIL single_empty got %0b exp 0", o_valid_sw); end
  endtask
  task automatic test_backpressure;
    logic [9:0] exp [5];
    i_ready_sw = 0;
    for (int k = 0; k < 5; k++) exp[k] = pkt(k[0], k[1], 8'h10 + 8'(k));
    for (int k = 0; k < 4; k++) begin
      drive(1, k[0], k[1], 8'h10 + 8'(k));
      tick;
    end
    vec++; if (o_count !== 3'd4) begin errs++; $display("FAIL bp_count got %0d exp 4", o_count); end
    vec++; if (o_ready !== 1'b0) begin errs++; $display("FAIL bp_ready got %0b exp 0", o_ready); end
    drive(1, 0, 0, 8'h14);
    tick;
    tick;
    vec++; if (o_count !== 3'd4) begin errs++; $display("FAIL bp_held_count got %0d exp 4", o_count); end
    vec++; if (o_data_sw !== exp[0]) begin errs++; $display("FAIL bp_stable got %h exp %h", o_data_sw, exp[0]); end
    i_ready_sw = 1;
    for (int j = 0; j < 5; j++) begin
      vec++; if (o_valid_sw !== 1'b1 || o_data_sw !== exp[j]) begin errs++; $display("FAIL bp_pop%0d got %b/%h exp 1/%h", j, o_valid_sw, o_data_sw, exp[j]); end
      if (j == 1) begin
        vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_again got %0b exp 1", o_ready); end
      end
      tick;
      if (j == 1) drive(0, 0, 0, 0);
    end
    vec++; if (o_count !== 3'd0 || o_valid_sw !== 1'b0) begin errs++; $display("FAIL bp_drained got %0d/%b exp 0/0", o_count, o_valid_sw); end
    vec++; if (o_inj_count !== 16'd6) begin errs++; $display("FAIL bp_inj got %0d exp 6", o_inj_count); end
  endtask
  task automatic test_concurrent;
    logic [9:0] exp [5];
    for (int k = 0; k < 5; k++) exp[k] = pkt(k[1], k[0], 8'h20 + 8'(k));
    i_ready_sw = 0;
    for (int k = 0; k < 2; k++) begin
      drive(1, exp[k][0], exp[k][1], exp[k][9:2]);
      tick;
    end
    vec++; if (o_count !== 3'd2) begin errs++; $display("FAIL conc_fill got %0d exp 2", o_count); end
    i_ready_sw = 1;
    for (int k = 2; k < 5; k++) begin
      drive(1, exp[k][0], exp[k][1], exp[k][9:2]);
      tick;
      vec++; if (o_count !== 3'd2 || o_data_sw !== exp[k-1]) begin errs++; $display("FAIL conc_step%0d got %0d/%h exp 2/%h", k, o_count, o_data_sw, exp[k-1]); end
    end
    drive(0, 0, 0, 0);
    tick;
    vec++; if (o_data_sw !== exp[4] || o_count !== 3'd1) begin errs++; $display("FAIL conc_last got %h/%0d exp %h/1", o_data_sw, o_count, exp[4]); end
    tick;
    vec++; if (o_inj_count !== 16'd11 || o_valid_sw !== 1'b0) begin errs++; $display("FAIL conc_inj got %0d/%b exp 11/0", o_inj_count, o_valid_sw); end
  endtask
  task automatic test_flush;
    i_ready_sw = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 8'h40 + 8'(k));
      tick;
    end
    vec++; if (o_count !== 3'd3) begin errs++; $display("FAIL flush_fill got %0d exp 3", o_count); end
    i_flush = 1;
    i_ready_sw = 1;
    tick;
    i_flush = 0;
    drive(0, 0, 0, 0);
    vec++; if (o_count !== 3'd0) begin errs++; $display("FAIL flush_count got %0d exp 0", o_count); end
    vec++; if (o_valid_sw !== 1'b0) begin errs++; $display("FAIL flush_valid got %0b exp 0", o_valid_sw); end
    vec++; if (o_inj_count !== 16'd11) begin errs++; $display("FAIL flush_inj got %0d exp 11", o_inj_count); end
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL flush_ready got %0b exp 1", o_ready); end
  endtask
  task automatic test_counter_wrap;
    rstn = 0;
    #2 rstn = 1;
    i_ready_sw = 1;
    for (int k = 0; k < 18; k++) begin
      drive(k < 17, k[0], k[1], 8'(k));
      tick;
    end
    drive(0, 0, 0, 0);
    vec++; if (w_count !== 3'd0) begin errs++; $display("FAIL wrap_count got %0d exp 0", w_count); end
    vec++; if (w_inj !== 4'd1) begin errs++; $display("FAIL wrap_inj4 got %0d exp 1", w_inj); end
    vec++; if (o_inj_count !== 16'd17) begin errs++; $display("FAIL wrap_inj16 got %0d exp 17", o_inj_count); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_concurrent;
    test_flush;
    test_counter_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
